// File: rtl/router_egress_arbiter_if.sv
// Egress byte bus from the arbiter to the downstream consumer.
// Valid/ready handshake; sop/eop frame the packet, parity_err qualifies the eop beat.
interface router_egress_arbiter_if;
    logic       egress_valid;
    logic       egress_ready;
    logic [7:0] egress_data;
    logic       egress_sop;
    logic       egress_eop;
    logic       parity_err;

    modport master (
        output egress_valid, egress_data, egress_sop, egress_eop, parity_err,
        input  egress_ready
    );

    modport slave (
        input  egress_valid, egress_data, egress_sop, egress_eop, parity_err,
        output egress_ready
    );
endinterface

// File: rtl/router_egress_arbiter.sv
// Packet round-robin arbiter draining three router FIFOs onto one 8-bit egress bus.
// Latency: request seen in IDLE -> first FIFO read next cycle -> first egress beat 3 cycles after request.
// Backpressure: reads stop in the same cycle that buffered plus in-flight bytes would exceed 2.
module router_egress_arbiter #(
    parameter int TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vld_out_0,
    input  logic       vld_out_1,
    input  logic       vld_out_2,
    input  logic [7:0] data_out_0,
    input  logic [7:0] data_out_1,
    input  logic [7:0] data_out_2,
    output logic       read_enb_0,
    output logic       read_enb_1,
    output logic       read_enb_2,
    router_egress_arbiter_if.master egress,
    output logic       timeout_err,
    output logic [1:0] grant,
    output logic       grant_valid
);
    localparam int SW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t     state, state_nxt;
    logic [1:0] grant_nxt, last_grant;
    logic [7:0] buf0, buf1;
    logic [1:0] occ;
    logic       inflight;
    logic [6:0] rd_cnt, out_cnt, total;
    logic       total_vld;
    logic [7:0] xor_q;
    logic [SW-1:0] starve;

    logic       vld_g, deq, room, want, rd, starving, eop;
    logic [7:0] dat_g;

    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
        logic [1:0] p;
        int idx;
        p = 2'd0;
        // Highest priority (offset 1) is evaluated last so it wins.
        for (int k = 3; k >= 1; k--) begin
            idx = (int'(last) + k) % 3;
            if (req[idx]) p = idx[1:0];
        end
        return p;
    endfunction

    always_comb begin
        vld_g = vld_out_2;
        dat_g = data_out_2;
        case (grant)
            2'd0: begin vld_g = vld_out_0; dat_g = data_out_0; end
            2'd1: begin vld_g = vld_out_1; dat_g = data_out_1; end
            default: ;
        endcase
    end

    assign egress.egress_valid = (occ != 2'd0);
    assign egress.egress_data  = buf0;
    assign egress.egress_sop   = egress.egress_valid && (out_cnt == 7'd0);
    assign eop                 = egress.egress_valid && total_vld && (out_cnt == total - 7'd1);
    assign egress.egress_eop   = eop;
    assign egress.parity_err   = eop && ((xor_q ^ buf0) != 8'd0);

    assign deq  = egress.egress_valid && egress.egress_ready;
    // Headroom: bytes that will sit in the buffer once this read lands must not exceed 2.
    assign room = ({1'b0, occ} + {2'b0, inflight}) <= (3'd1 + {2'b0, deq});
    assign want = total_vld ? (rd_cnt < total) : (rd_cnt < 7'd2);
    assign rd   = (state == XFER) && vld_g && room && want;
    assign starving    = (state == XFER) && want && !vld_g;
    assign timeout_err = starving && (starve == SW'(TIMEOUT - 1));

    assign read_enb_0 = rd && (grant == 2'd0);
    assign read_enb_1 = rd && (grant == 2'd1);
    assign read_enb_2 = rd && (grant == 2'd2);

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            IDLE: if (vld_out_0 || vld_out_1 || vld_out_2) begin
                state_nxt = XFER;
                grant_nxt = rr_pick(last_grant, {vld_out_2, vld_out_1, vld_out_0});
            end
            XFER: if (timeout_err)                          state_nxt = IDLE;
                  else if (total_vld && rd_cnt == total)    state_nxt = DONE;
            DONE: if (eop && deq)                           state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 2'd0;
            grant_valid <= 1'b0;
            last_grant  <= 2'd2;
            buf0        <= 8'd0;
            buf1        <= 8'd0;
            occ         <= 2'd0;
            inflight    <= 1'b0;
            rd_cnt      <= 7'd0;
            out_cnt     <= 7'd0;
            total       <= 7'd0;
            total_vld   <= 1'b0;
            xor_q       <= 8'd0;
            starve      <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            if (state == IDLE && state_nxt == XFER) grant_valid <= 1'b1;
            if (state != IDLE && state_nxt == IDLE) begin
                // End of packet or abort: anything still buffered is dropped.
                grant_valid <= 1'b0;
                last_grant  <= grant;
                occ         <= 2'd0;
                inflight    <= 1'b0;
                rd_cnt      <= 7'd0;
                out_cnt     <= 7'd0;
                total       <= 7'd0;
                total_vld   <= 1'b0;
                xor_q       <= 8'd0;
                starve      <= '0;
            end else begin
                inflight <= rd;
                occ      <= occ + {1'b0, inflight} - {1'b0, deq};
                if (rd) rd_cnt <= rd_cnt + 7'd1;
                if (deq) begin
                    out_cnt <= out_cnt + 7'd1;
                    xor_q   <= xor_q ^ buf0;
                    if (occ == 2'd2) begin
                        buf0 <= buf1;
                        if (inflight) buf1 <= dat_g;
                    end else if (inflight) begin
                        buf0 <= dat_g;
                    end
                end else if (inflight) begin
                    if (occ == 2'd0) buf0 <= dat_g;
                    else             buf1 <= dat_g;
                end
                if (inflight && !total_vld) begin
                    total_vld <= 1'b1;
                    total     <= {1'b0, dat_g[7:2]} + 7'd2;
                end
                if (rd)            starve <= '0;
                else if (starving) starve <= starve + SW'(1);
            end
        end
    end
endmodule

// File: tb/tb_router_egress_arbiter.sv
// Directed bench for router_egress_arbiter: FIFO models on three ports, egress monitor, hand-computed vectors.
module tb_router_egress_arbiter;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic [7:0] data_out_0, data_out_1, data_out_2;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic       timeout_err;
    logic [1:0] grant;
    logic       grant_valid;

    router_egress_arbiter_if eg();

    router_egress_arbiter #(.TIMEOUT(30)) dut (
        .clk(clk), .reset(reset),
        .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
        .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
        .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
        .egress(eg),
        .timeout_err(timeout_err), .grant(grant), .grant_valid(grant_valid)
    );

    // FIFO models: bench pushes bytes, the DUT pops with one-cycle read latency
    logic [7:0] mem [3][256];
    logic [7:0] wr_ptr [3];
    logic [7:0] rd_ptr [3];
    logic       flush;

    assign vld_out_0 = (rd_ptr[0] != wr_ptr[0]);
    assign vld_out_1 = (rd_ptr[1] != wr_ptr[1]);
    assign vld_out_2 = (rd_ptr[2] != wr_ptr[2]);

    always @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < 3; i++) rd_ptr[i] <= wr_ptr[i];
        end else begin
            if (read_enb_0) begin data_out_0 <= mem[0][rd_ptr[0]]; rd_ptr[0] <= rd_ptr[0] + 8'd1; end
            if (read_enb_1) begin data_out_1 <= mem[1][rd_ptr[1]]; rd_ptr[1] <= rd_ptr[1] + 8'd1; end
            if (read_enb_2) begin data_out_2 <= mem[2][rd_ptr[2]]; rd_ptr[2] <= rd_ptr[2] + 8'd1; end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int b_dat[$], b_sop[$], b_eop[$], b_perr[$], b_cyc[$], b_gnt[$];
    int r_port[$], r_cyc[$], t_cyc[$];
    int pend = 0, pend_max = 0, viol = 0;

    always @(negedge clk) begin
        if (reset) begin
            pend = 0;
        end else begin
            if (pend > pend_max) pend_max = pend;
            if (eg.egress_valid && eg.egress_ready) begin
                b_dat.push_back(int'(eg.egress_data));
                b_sop.push_back(int'(eg.egress_sop));
                b_eop.push_back(int'(eg.egress_eop));
                b_perr.push_back(int'(eg.parity_err));
                b_cyc.push_back(cyc);
                b_gnt.push_back(int'(grant));
                pend = pend - 1;
            end
            if (read_enb_0) begin
                if (!vld_out_0 || !grant_valid || grant != 2'd0) viol++;
                pend++; r_port.push_back(0); r_cyc.push_back(cyc);
            end
            if (read_enb_1) begin
                if (!vld_out_1 || !grant_valid || grant != 2'd1) viol++;
                pend++; r_port.push_back(1); r_cyc.push_back(cyc);
            end
            if (read_enb_2) begin
                if (!vld_out_2 || !grant_valid || grant != 2'd2) viol++;
                pend++; r_port.push_back(2); r_cyc.push_back(cyc);
            end
            if (timeout_err) begin
                t_cyc.push_back(cyc);
                pend = 0;
            end
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic push(input int p, input logic [7:0] b);
        mem[p][wr_ptr[p]] = b;
        wr_ptr[p] = wr_ptr[p] + 8'd1;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k;
        k = 0;
        while (b_dat.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("beats_arrived", int'(b_dat.size() >= n), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        flush = 1'b0;
    endtask

    int b0, r0, t0, c0, k, s;
    logic [7:0] e2_dat [12];
    int         e2_gnt [12];
    logic [7:0] e3_dat [8];

    initial begin
        reset = 1'b1;
        flush = 1'b1;
        eg.egress_ready = 1'b1;
        for (int i = 0; i < 3; i++) wr_ptr[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_egress_valid", int'(eg.egress_valid), 0);
        chk("rst_grant_valid", int'(grant_valid), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_timeout_err", int'(timeout_err), 0);
        chk("rst_sop_eop_perr", int'({eg.egress_sop, eg.egress_eop, eg.parity_err}), 0);
        chk("rst_read_enb", int'({read_enb_2, read_enb_1, read_enb_0}), 0);
        reset = 1'b0;
        flush = 1'b0;

        // Single packet on port 1
        @(posedge clk); #1;
        b0 = b_dat.size(); r0 = r_port.size();
        push(1, 8'h0D); push(1, 8'hAA); push(1, 8'hBB); push(1, 8'hCC); push(1, 8'hD0);
        c0 = cyc;
        wait_beats(b0 + 5, 40);
        #1;
        chk("t1_idle_grant_valid", int'(grant_valid), 0);
        chk("t1_read_count", r_port.size() - r0, 5);
        chk("t1_read_port", qget(r_port, r0), 1);
        chk("t1_first_read_cyc", qget(r_cyc, r0) - c0, 1);
        chk("t1_last_read_cyc", qget(r_cyc, r0 + 4) - c0, 5);
        chk("t1_first_beat_cyc", qget(b_cyc, b0) - c0, 3);
        chk("t1_last_beat_cyc", qget(b_cyc, b0 + 4) - c0, 7);
        chk("t1_dat0", qget(b_dat, b0), 'h0D);
        chk("t1_dat2", qget(b_dat, b0 + 2), 'hBB);
        chk("t1_dat4", qget(b_dat, b0 + 4), 'hD0);
        chk("t1_sop_first", qget(b_sop, b0), 1);
        chk("t1_eop_last", qget(b_eop, b0 + 4), 1);
        s = 0;
        for (int i = 0; i < 5; i++) s += qget(b_sop, b0 + i) + qget(b_eop, b0 + i) + qget(b_perr, b0 + i);
        chk("t1_flag_total", s, 2);

        // Three ports requesting after reset: round robin 0,1,2,0
        do_reset();
        e2_dat = '{8'h04, 8'h11, 8'h15, 8'h05, 8'h22, 8'h27, 8'h06, 8'h33, 8'h35, 8'h04, 8'h44, 8'h40};
        e2_gnt = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 0, 0};
        b0 = b_dat.size();
        push(0, 8'h04); push(0, 8'h11); push(0, 8'h15);
        push(0, 8'h04); push(0, 8'h44); push(0, 8'h40);
        push(1, 8'h05); push(1, 8'h22); push(1, 8'h27);
        push(2, 8'h06); push(2, 8'h33); push(2, 8'h35);
        wait_beats(b0 + 12, 120);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t2_dat%0d", i), qget(b_dat, b0 + i), int'(e2_dat[i]));
            chk($sformatf("t2_gnt%0d", i), qget(b_gnt, b0 + i), e2_gnt[i]);
            chk($sformatf("t2_sop_eop%0d", i), qget(b_sop, b0 + i) * 2 + qget(b_eop, b0 + i),
                (i % 3 == 0) ? 2 : ((i % 3 == 2) ? 1 : 0));
        end
        chk("t2_pkt_gap", qget(b_cyc, b0 + 3) - qget(b_cyc, b0 + 2), 4);

        // Port 0, len=6 with egress_ready toggling 1,0,0
        e3_dat = '{8'h18, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h1F};
        @(posedge clk); #1;
        b0 = b_dat.size(); r0 = r_port.size();
        for (int i = 0; i < 8; i++) push(0, e3_dat[i]);
        k = 0;
        while (b_dat.size() < b0 + 8 && k < 150) begin
            eg.egress_ready = (k % 3 == 0);
            @(posedge clk); #1;
            k++;
        end
        eg.egress_ready = 1'b1;
        chk("t3_beats", b_dat.size() - b0, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t3_dat%0d", i), qget(b_dat, b0 + i), int'(e3_dat[i]));
        chk("t3_eop", qget(b_eop, b0 + 7), 1);
        chk("t3_perr", qget(b_perr, b0 + 7), 0);
        chk("t3_reads", r_port.size() - r0, 8);
        chk("t3_occ_max", int'(pend_max <= 2), 1);

        // Corrupted parity on port 1
        repeat (3) @(posedge clk); #1;
        b0 = b_dat.size();
        push(1, 8'h0D); push(1, 8'hAA); push(1, 8'hBB); push(1, 8'hCC); push(1, 8'hD1);
        wait_beats(b0 + 5, 40);
        s = 0;
        for (int i = 0; i < 4; i++) s += qget(b_perr, b0 + i);
        chk("t4_perr_payload", s, 0);
        chk("t4_perr_eop", qget(b_perr, b0 + 4), 1);
        chk("t4_eop", qget(b_eop, b0 + 4), 1);

        // Truncated port 2 packet times out; pending port 0 goes next
        repeat (3) @(posedge clk); #1;
        b0 = b_dat.size(); r0 = r_port.size(); t0 = t_cyc.size();
        push(2, 8'h16); push(2, 8'h51); push(2, 8'h52);
        push(0, 8'h04); push(0, 8'h11); push(0, 8'h15);
        k = 0;
        while (t_cyc.size() == t0 && k < 80) begin
            @(posedge clk);
            k++;
        end
        chk("t5_timeout_seen", t_cyc.size() - t0, 1);
        #1;
        chk("t5_grant_valid_after", int'(grant_valid), 0);
        chk("t5_port2_reads", r_port.size() - r0, 3);
        chk("t5_read_port", qget(r_port, r0 + 2), 2);
        chk("t5_timeout_delay", qget(t_cyc, t0) - qget(r_cyc, r0 + 2), 30);
        chk("t5_partial_beats", b_dat.size() - b0, 3);
        chk("t5_partial_no_eop", qget(b_eop, b0) + qget(b_eop, b0 + 1) + qget(b_eop, b0 + 2), 0);
        wait_beats(b0 + 6, 40);
        chk("t5_next_gnt", qget(b_gnt, b0 + 3), 0);
        chk("t5_next_hdr", qget(b_dat, b0 + 3), 'h04);
        chk("t5_next_sop", qget(b_sop, b0 + 3), 1);
        chk("t5_next_eop", qget(b_eop, b0 + 5), 1);
        chk("t5_single_pulse", t_cyc.size() - t0, 1);

        // Reset mid-payload, then port 0 has priority again
        repeat (3) @(posedge clk); #1;
        b0 = b_dat.size();
        push(1, 8'h0D); push(1, 8'hAA); push(1, 8'hBB); push(1, 8'hCC); push(1, 8'hD0);
        wait_beats(b0 + 2, 40);
        #1;
        chk("t6_pre_valid", int'(eg.egress_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_egress_valid", int'(eg.egress_valid), 0);
        chk("t6_rst_read_enb", int'({read_enb_2, read_enb_1, read_enb_0}), 0);
        chk("t6_rst_grant_valid", int'(grant_valid), 0);
        flush = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        flush = 1'b0;
        b0 = b_dat.size();
        push(2, 8'h06); push(2, 8'h33); push(2, 8'h35);
        push(1, 8'h05); push(1, 8'h22); push(1, 8'h27);
        push(0, 8'h04); push(0, 8'h44); push(0, 8'h40);
        wait_beats(b0 + 9, 80);
        chk("t6_first_gnt", qget(b_gnt, b0), 0);
        chk("t6_first_dat", qget(b_dat, b0 + 1), 'h44);
        chk("t6_second_gnt", qget(b_gnt, b0 + 3), 1);
        chk("t6_third_gnt", qget(b_gnt, b0 + 6), 2);

        chk("read_rule_violations", viol, 0);
        chk("occ_max_overall", int'(pend_max <= 2), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/router_egress_arbiter.md
# router_egress_arbiter

Packet-level round-robin arbiter that drains the three router output FIFOs onto one shared 8-bit egress bus with a valid/ready handshake. It sits downstream of the three router FIFOs, in place of the three per-port read clients. It drives each FIFO's read enable, frames packets (sop/eop) from the header length field, and checks parity. It aborts a stalled packet after a programmable empty-FIFO timeout.

## Interface
- TIMEOUT, 30: consecutive starved cycles in XFER before abort (≥2).
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- vld_out_0/1/2  in  1  FIFO i non-empty
- data_out_0/1/2  in  8  FIFO i read data, valid the cycle after read_enb_i
- read_enb_0/1/2  out  1  FIFO i pop
- egress_ready  in  1  downstream accepts beat
- egress_valid  out  1  beat valid
- egress_data  out  8  beat byte
- egress_sop  out  1  beat is header
- egress_eop  out  1  beat is parity byte
- parity_err  out  1  with eop beat: XOR of all packet bytes ≠ 0
- timeout_err  out  1  one-cycle abort pulse
- grant  out  2  granted port (0–2)
- grant_valid  out  1  a packet is owned

## Operation
- Packet format: header {len[7:2], addr[1:0]}, len payload bytes, parity byte; total = len+2 (len=0 legal, total=2).
- Internal: 2-entry output buffer (occ 0–2), inflight flag (read issued last cycle), rd_cnt (reads issued this packet), out_cnt (beats sent), total (latched), running XOR, last_grant, starve counter.
- States: IDLE, XFER, DONE.
- IDLE: if any vld_out_i, pick first requester starting at (last_grant+1) mod 3; register grant, grant_valid=1, go XFER. Else stay.
- XFER: read_enb_g = vld_out_g & (occ + inflight − deq ≤ 1) & (total latched ? rd_cnt < total : rd_cnt < 2), with deq = egress_valid & egress_ready. Non-granted read_enb always 0. read_enb is combinational, same-cycle on egress_ready.
- A byte on data_out_g is written into the buffer at the end of the cycle after its read. The first byte written latches total = data[7:2]+2.
- When rd_cnt reaches total → DONE.
- Egress: egress_valid = occ≠0, data = buffer head. sop when out_cnt==0. eop when out_cnt==total−1 (total latched). parity_err = eop & ((xor ^ egress_data) ≠ 0). out_cnt/xor advance on deq.
- DONE: on the eop handshake → IDLE, last_grant ← grant, grant_valid ← 0, counters/xor cleared.
- Timeout: in XFER, while a read is wanted by count but vld_out_g=0, starve counts up; any read clears it. On reaching TIMEOUT: pulse timeout_err, flush buffer (occ←0), drop the remainder, update last_grant → IDLE. Bytes already sent are not recalled.
- Buffer never exceeds 2; no FIFO read while vld_out_g=0; no read beyond total.

## Timing
- Reset (async, immediate): all outputs 0, state IDLE, last_grant=2 (port 0 first), counters 0.
- Latency: request seen in IDLE at cycle 0 → grant_valid/first read_enb cycle 1 → data_out cycle 2 → egress_valid cycle 3.
- Throughput: one byte/cycle with egress_ready held high and the FIFO non-empty.
- Packet-to-packet gap: the eop handshake cycle, then 1 IDLE cycle, then a 3-cycle refill.
- Backpressure: read_enb drops in the same cycle the headroom rule fails. With egress_ready held low, at most 2 buffered bytes plus 0 inflight.
- Simultaneous requests are resolved only in IDLE; requests arriving mid-packet wait.
- Reset mid-packet: everything clears. FIFOs are unaffected; any partial packet is left in the FIFO.

## Test plan
- Single packet, port 1: 0D, AA, BB, CC, parity 0D^AA^BB^CC → read_enb_1 high 5 consecutive cycles from cycle 1; egress beats 0D(sop)…parity(eop) at cycles 3–7; parity_err=0; back to IDLE.
- All three ports hold 3-byte packets after reset → grant sequence 0,1,2,0; no interleaving of bytes between packets.
- Port 0 packet len=6, egress_ready toggling 1,0,0,1… → all 8 bytes delivered in order, none duplicated; occ never exceeds 2; read_enb_0 low whenever headroom is exhausted.
- Corrupt parity byte (XOR off by 01) → parity_err=1 on the eop beat only.
- Port 2 header len=5, only 2 payload bytes written, then vld_out_2 low → timeout_err pulse exactly TIMEOUT(30) cycles after the last read; grant_valid 0; a pending port 0 request is granted next.
- reset asserted mid-payload → egress_valid, read_enb_*, grant_valid go 0 immediately; after release, port 0 has priority.
